fft_bf2_twiddle_mul: RTL and testbench

- Radix-2 DIT butterfly with a twiddle multiply. Sits directly downstream of the 8-entry twiddle LUT and consumes its packed 24-bit W word.
- Per accepted pair (a, b) and twiddle W it computes P = b·W, then X0 = (a + P)/2 and X1 = (a − P)/2.
- Three-stage pipeline with valid/ready on both sides. The FFT stage controller drives the input side; the stage memory or next stage drains the output.

---
 rtl/fft_bf2_twiddle_mul_if.sv | 27 ++
 rtl/fft_bf2_twiddle_mul.sv | 153 +++++++++++++++
 tb/tb_fft_bf2_twiddle_mul.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_bf2_twiddle_mul_if.sv
// Valid/ready bus for the radix-2 twiddle butterfly.
// Carries the input pair, twiddle, results and the sticky saturation flag.
interface fft_bf2_twiddle_mul_if #(
    parameter int DW = 12
);
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] a_in;
    logic [2*DW-1:0] b_in;
    logic [2*DW-1:0] w_in;
    logic            out_valid;
    logic            out_ready;
    logic [2*DW-1:0] x0_out;
    logic [2*DW-1:0] x1_out;
    logic            sat_flag;
    logic            sat_clr;

    modport master (
        output in_valid, a_in, b_in, w_in, out_ready, sat_clr,
        input  in_ready, out_valid, x0_out, x1_out, sat_flag
    );

    modport slave (
        input  in_valid, a_in, b_in, w_in, out_ready, sat_clr,
        output in_ready, out_valid, x0_out, x1_out, sat_flag
    );
endinterface

// File: rtl/fft_bf2_twiddle_mul.sv
// Radix-2 DIT butterfly: P = b*W, X0 = (a+P)/2, X1 = (a-P)/2.
// Three stages (register, multiply, add/scale/saturate) under one advance enable.
module fft_bf2_twiddle_mul #(
    parameter int DW      = 12,
    parameter int TW_FRAC = 10
) (
    input logic                  clk,
    input logic                  reset_p,
    fft_bf2_twiddle_mul_if.slave bus
);
    localparam int PW = 2 * DW;
    localparam int SW = DW + 3;
    localparam int AW = DW + 4;
    localparam logic signed [AW-1:0] SMAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = ~SMAX;

    logic                 w_adv;
    logic                 r_v1;
    logic                 r_v2;
    logic                 r_v3;
    logic [PW-1:0]        r_a1;
    logic [PW-1:0]        r_b1;
    logic [PW-1:0]        r_w1;
    logic [PW-1:0]        r_a2;
    logic signed [PW-1:0] r_rr;
    logic signed [PW-1:0] r_ii;
    logic signed [PW-1:0] r_ri;
    logic signed [PW-1:0] r_ir;
    logic [PW-1:0]        r_x0;
    logic [PW-1:0]        r_x1;
    logic                 r_sat;

    assign w_adv         = bus.out_ready | ~r_v3;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_v3;
    assign bus.x0_out    = r_x0;
    assign bus.x1_out    = r_x1;
    assign bus.sat_flag  = r_sat;

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_v1 <= 1'b0;
            r_a1 <= '0;
            r_b1 <= '0;
            r_w1 <= '0;
        end else if (w_adv) begin
            r_v1 <= bus.in_valid;
            r_a1 <= bus.a_in;
            r_b1 <= bus.b_in;
            r_w1 <= bus.w_in;
        end
    end

    // Operands widened to the product width so the 24-bit result is exact.
    logic signed [PW-1:0] w_br;
    logic signed [PW-1:0] w_bi;
    logic signed [PW-1:0] w_wr;
    logic signed [PW-1:0] w_wi;

    assign w_br = {{DW{r_b1[PW-1]}}, r_b1[PW-1:DW]};
    assign w_bi = {{DW{r_b1[DW-1]}}, r_b1[DW-1:0]};
    assign w_wr = {{DW{r_w1[PW-1]}}, r_w1[PW-1:DW]};
    assign w_wi = {{DW{r_w1[DW-1]}}, r_w1[DW-1:0]};

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_v2 <= 1'b0;
            r_a2 <= '0;
            r_rr <= '0;
            r_ii <= '0;
            r_ri <= '0;
            r_ir <= '0;
        end else if (w_adv) begin
            r_v2 <= r_v1;
            r_a2 <= r_a1;
            r_rr <= w_br * w_wr;
            r_ii <= w_bi * w_wi;
            r_ri <= w_br * w_wi;
            r_ir <= w_bi * w_wr;
        end
    end

    logic signed [PW:0]   w_dr;
    logic signed [PW:0]   w_di;
    logic signed [PW:0]   w_drs;
    logic signed [PW:0]   w_dis;
    logic signed [SW-1:0] w_pr;
    logic signed [SW-1:0] w_pi;
    logic signed [AW-1:0] w_ar;
    logic signed [AW-1:0] w_ai;
    logic signed [AW-1:0] w_per;
    logic signed [AW-1:0] w_pei;
    logic [DW:0]          w_s0r;
    logic [DW:0]          w_s0i;
    logic [DW:0]          w_s1r;
    logic [DW:0]          w_s1i;
    logic                 w_clip;

    function automatic logic [DW:0] sat_half(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] h;
        logic [DW:0]          res;
        h = s >>> 1;
        if (h > SMAX) begin
            res = {1'b1, SMAX[DW-1:0]};
        end else if (h < SMIN) begin
            res = {1'b1, SMIN[DW-1:0]};
        end else begin
            res = {1'b0, h[DW-1:0]};
        end
        return res;
    endfunction

    assign w_dr  = {r_rr[PW-1], r_rr} - {r_ii[PW-1], r_ii};
    assign w_di  = {r_ri[PW-1], r_ri} + {r_ir[PW-1], r_ir};
    assign w_drs = w_dr >>> TW_FRAC;
    assign w_dis = w_di >>> TW_FRAC;
    assign w_pr  = w_drs[SW-1:0];
    assign w_pi  = w_dis[SW-1:0];

    assign w_ar  = {{(AW - DW){r_a2[PW-1]}}, r_a2[PW-1:DW]};
    assign w_ai  = {{(AW - DW){r_a2[DW-1]}}, r_a2[DW-1:0]};
    assign w_per = {{(AW - SW){w_pr[SW-1]}}, w_pr};
    assign w_pei = {{(AW - SW){w_pi[SW-1]}}, w_pi};

    assign w_s0r  = sat_half(w_ar + w_per);
    assign w_s0i  = sat_half(w_ai + w_pei);
    assign w_s1r  = sat_half(w_ar - w_per);
    assign w_s1i  = sat_half(w_ai - w_pei);
    assign w_clip = w_s0r[DW] | w_s0i[DW] | w_s1r[DW] | w_s1i[DW];

    // Results only reload on valid data so a bubble leaves the last value visible.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            r_v3  <= 1'b0;
            r_x0  <= '0;
            r_x1  <= '0;
            r_sat <= 1'b0;
        end else begin
            if (w_adv) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_x0 <= {w_s0r[DW-1:0], w_s0i[DW-1:0]};
                    r_x1 <= {w_s1r[DW-1:0], w_s1i[DW-1:0]};
                end
            end
            if (w_adv & r_v2 & w_clip) begin
                r_sat <= 1'b1;
            end else if (bus.sat_clr) begin
                r_sat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_bf2_twiddle_mul.sv
// Scoreboard bench for fft_bf2_twiddle_mul with an integer reference model.
// Directed vectors, backpressure, bubbles, mid-stream reset, random traffic.
module tb_fft_bf2_twiddle_mul;
    logic clk = 1'b0;
    logic reset_p;
    always #5 clk = ~clk;

    fft_bf2_twiddle_mul_if #(.DW(12)) bus ();

    fft_bf2_twiddle_mul #(
        .DW(12),
        .TW_FRAC(10)
    ) dut (
        .clk(clk),
        .reset_p(reset_p),
        .bus(bus)
    );

    typedef struct {
        logic [23:0] x0;
        logic [23:0] x1;
        bit          clip;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pop = 0;

    function automatic int fdiv(int n, int d);
        int r;
        r = n / d;
        if ((n % d) != 0 && n < 0) r = r - 1;
        return r;
    endfunction

    function automatic int cl(int v);
        return (v > 2047) ? 2047 : ((v < -2048) ? -2048 : v);
    endfunction

    function automatic exp_t model(logic [23:0] a, logic [23:0] b, logic [23:0] w);
        int   ar, ai, br, bi, wr, wi, pr, pi, v;
        int   s[4];
        logic [11:0] t[4];
        exp_t e;
        ar = int'($signed(a[23:12]));
        ai = int'($signed(a[11:0]));
        br = int'($signed(b[23:12]));
        bi = int'($signed(b[11:0]));
        wr = int'($signed(w[23:12]));
        wi = int'($signed(w[11:0]));
        pr = fdiv(br * wr - bi * wi, 1024);
        pi = fdiv(br * wi + bi * wr, 1024);
        s[0] = fdiv(ar + pr, 2);
        s[1] = fdiv(ai + pi, 2);
        s[2] = fdiv(ar - pr, 2);
        s[3] = fdiv(ai - pi, 2);
        e.clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            v = cl(s[i]);
            if (v != s[i]) e.clip = 1'b1;
            t[i] = v[11:0];
        end
        e.x0 = {t[0], t[1]};
        e.x1 = {t[2], t[3]};
        return e;
    endfunction

    function automatic logic [23:0] pk(int r, int i);
        return {r[11:0], i[11:0]};
    endfunction

    task automatic check(string nm, logic [23:0] got, logic [23:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic tmo(string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s timeout", nm);
    endtask

    // Accepted inputs become expected outputs.
    always @(negedge clk) begin
        if (!reset_p && bus.in_valid && bus.in_ready)
            q.push_back(model(bus.a_in, bus.b_in, bus.w_in));
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset_p && bus.out_valid && bus.out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected x0=%h x1=%h", bus.x0_out, bus.x1_out);
            end else begin
                e = q.pop_front();
                n_pop++;
                if (bus.x0_out !== e.x0 || bus.x1_out !== e.x1) begin
                    n_bad++;
                    $display("FAIL sb_data x0=%h x1=%h expected x0=%h x1=%h",
                             bus.x0_out, bus.x1_out, e.x0, e.x1);
                end
                if (e.clip) begin
                    n_cmp++;
                    if (bus.sat_flag !== 1'b1) begin
                        n_bad++;
                        $display("FAIL sb_sat sat_flag=%b expected=1", bus.sat_flag);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [23:0] a, logic [23:0] b, logic [23:0] w);
        bit ok;
        ok = 1'b0;
        bus.a_in = a;
        bus.b_in = b;
        bus.w_in = w;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo("send");
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(24'($urandom), 24'($urandom), 24'($urandom));
    endtask

    task automatic expect_out(string nm, logic [23:0] e0, logic [23:0] e1);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                check({nm, "_x0"}, bus.x0_out, e0);
                check({nm, "_x1"}, bus.x1_out, e1);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) tmo(nm);
        step();
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        bus.out_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (q.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) tmo("drain");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] x0s, x1s;
        bit          pat[5];
        bit          ov[9];
        bit          done;
        bit          seen;
        int          p0, cnt;

        reset_p       = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.w_in      = '0;
        bus.out_ready = 1'b1;
        bus.sat_clr   = 1'b0;
        #1;
        check("rst_out_valid", 24'(bus.out_valid), 24'd0);
        check("rst_x0", bus.x0_out, 24'd0);
        check("rst_x1", bus.x1_out, 24'd0);
        check("rst_sat", 24'(bus.sat_flag), 24'd0);
        repeat (3) step();
        reset_p = 1'b0;
        step();

        send(pk(100, 50), pk(200, -100), 24'h400000);
        expect_out("w_one", pk(150, -25), pk(-50, 75));

        send(pk(0, 0), pk(200, -100), 24'h000C00);
        expect_out("w_negj", pk(-50, -100), pk(50, 100));

        send(pk(2047, 0), pk(2047, 2047), 24'h2D4D2C);
        expect_out("sat", pk(2047, 0), pk(-424, 0));
        check("sat_set", 24'(bus.sat_flag), 24'd1);
        bus.sat_clr = 1'b1;
        step();
        bus.sat_clr = 1'b0;
        check("sat_clr", 24'(bus.sat_flag), 24'd0);
        drain();

        // Backpressure: six items, output held for four cycles.
        p0 = n_pop;
        bus.out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand();
            end
            begin
                seen = 1'b0;
                for (int t = 0; t < 40; t++) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (!seen) tmo("bp_first_valid");
                x0s = bus.x0_out;
                x1s = bus.x1_out;
                for (int c = 0; c < 4; c++) begin
                    if (c > 0) @(negedge clk);
                    check("bp_in_ready", 24'(bus.in_ready), 24'd0);
                    check("bp_x0_hold", bus.x0_out, x0s);
                    check("bp_x1_hold", bus.x1_out, x1s);
                end
                step();
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 24'(n_pop - p0), 24'd6);

        // Bubbles: in_valid 1,0,1,1,0 reappears three cycles later.
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 9; k++) begin
            bus.in_valid = (k < 5) ? pat[k] : 1'b0;
            bus.a_in = 24'($urandom);
            bus.b_in = 24'($urandom);
            bus.w_in = 24'($urandom);
            @(negedge clk);
            ov[k] = bus.out_valid;
            step();
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) check("bub_lead", 24'(ov[k]), 24'd0);
        for (int k = 0; k < 5; k++) check("bub_pat", 24'(ov[k+3]), 24'(pat[k]));
        drain();

        // Reset with one output held and two items in flight.
        bus.out_ready = 1'b0;
        send(pk(2047, 0), pk(2047, 2047), 24'h2D4D2C);
        send_rand();
        send_rand();
        step();
        check("pre_rst_valid", 24'(bus.out_valid), 24'd1);
        check("pre_rst_sat", 24'(bus.sat_flag), 24'd1);
        reset_p = 1'b1;
        #1;
        q.delete();
        check("mid_rst_valid", 24'(bus.out_valid), 24'd0);
        check("mid_rst_x0", bus.x0_out, 24'd0);
        check("mid_rst_x1", bus.x1_out, 24'd0);
        check("mid_rst_sat", 24'(bus.sat_flag), 24'd0);
        step();
        step();
        reset_p = 1'b0;
        bus.out_ready = 1'b1;
        cnt = 0;
        for (int t = 0; t < 8; t++) begin
            @(negedge clk);
            if (bus.out_valid) cnt++;
        end
        check("post_rst_stale", 24'(cnt), 24'd0);
        step();

        // Random traffic with random gaps and backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 250; i++) begin
                    repeat ($urandom_range(0, 2)) step();
                    send_rand();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
            end
        join
        drain();
        check("end_queue_empty", 24'(q.size()), 24'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
